uart_tx_buf: RTL and testbench

- Byte-stream sink placed directly downstream of the string display stage; consumes its strobe/byte pairs (a one-cycle write strobe with a byte held valid in the same cycle).
- Buffers bytes in a FIFO and serializes each byte as an 8N1 UART frame on txd, LSB first.
- Decouples the bursty producer (one byte every 2 cycles) from the much slower serial line.

---
 rtl/uart_tx_buf.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buf
// Brief    : FIFO-buffered 8N1 UART transmitter, LSB first, idle-high txd.
//            Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buf #(
    parameter int CLK_PER_BIT = 104,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int c_DEPTH  = 2 ** DEPTH_LOG2;
    localparam int c_BAUD_W = $clog2(CLK_PER_BIT);
    localparam int c_CNT_W  = DEPTH_LOG2 + 1;

    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]    c_CNT_FULL  = c_CNT_W'(c_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [c_BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic [7:0]            mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;

    logic                  do_push;
    logic                  do_pop;
    logic                  baud_end;
    logic [7:0]            head;

    assign head    = mem_q[rd_ptr_q];
    assign do_push = wr & ~full_q;

    // Transmit sequencer; txd_d is the level for the cycle after this edge.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        do_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        baud_end = (baud_q == c_BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty_q) begin
                    do_pop   = 1'b1;
                    state_d  = S_START;
                    baud_d   = '0;
                    shift_d  = head;
                    txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    txd_d   = 1'b1;
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back frames: reload straight into START, no idle bit.
                    if (!empty_q) begin
                        do_pop   = 1'b1;
                        state_d  = S_START;
                        shift_d  = head;
                        txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d  = S_IDLE;
                        txd_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr & full_q);

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == c_CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    assign txd   = txd_q;
    assign busy  = busy_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buf
// Brief    : Directed self-checking bench for uart_tx_buf (CLK_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd, busy, full, empty, ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_buf #(
        .CLK_PER_BIT (CPB),
        .DEPTH_LOG2  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .din   (din),
        .txd   (txd),
        .busy  (busy),
        .full  (full),
        .empty (empty),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish before 1000000 ns");
        $fatal(1);
    end

    // seq lists data bits in transmission order (LSB first), hand-derived.
    typedef struct {
        logic [7:0] din;
        logic [0:7] seq;
        logic       par;
    } vec_t;

    vec_t vecs [6];
    logic [7:0] burst_bytes [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic exp_bit;
        @(negedge clk); wr = 1'b1; din = v.din;
        @(negedge clk); wr = 1'b0;
        chk($sformatf("sb_%02h_empty_after_wr", v.din), {31'd0, empty}, 32'd0);
        chk($sformatf("sb_%02h_busy_before_start", v.din), {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk($sformatf("sb_%02h_empty_at_pop", v.din), {31'd0, empty}, 32'd1);
        for (int k = 0; k < FRAME_BITS * CPB; k++) begin
            int bi;
            bi = k / CPB;
            if (bi == 0)       exp_bit = 1'b0;
            else if (bi <= 8)  exp_bit = v.seq[bi-1];
`ifdef UART_TX_PARITY_EN
            else if (bi == 9)  exp_bit = v.par;
`endif
            else               exp_bit = 1'b1;
            chk($sformatf("sb_%02h_txd_c%0d", v.din, k), {31'd0, txd}, {31'd0, exp_bit});
            chk($sformatf("sb_%02h_busy_c%0d", v.din, k), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk($sformatf("sb_%02h_busy_end", v.din), {31'd0, busy}, 32'd0);
        chk($sformatf("sb_%02h_txd_end", v.din), {31'd0, txd}, 32'd1);
    endtask

    // Returns one negedge past the frame end, i.e. where a back-to-back start begins.
    task automatic recv_frame(input int max_wait, output logic [7:0] b);
        int w;
        w = 0;
        b = 8'h00;
        while (txd !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("rx_start_edge", {31'd0, txd}, 32'd0);
        if (txd !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        chk("rx_start_mid", {31'd0, txd}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("rx_parity", {31'd0, txd}, {31'd0, ^b});
`endif
        repeat (CPB) @(negedge clk);
        chk("rx_stop", {31'd0, txd}, 32'd1);
        repeat (CPB - CPB / 2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        int         c1;
        bit         idle_ok;

        vecs[0] = '{din: 8'h41, seq: 8'b1000_0010, par: 1'b0};
        vecs[1] = '{din: 8'h43, seq: 8'b1100_0010, par: 1'b1};
        vecs[2] = '{din: 8'h00, seq: 8'b0000_0000, par: 1'b0};
        vecs[3] = '{din: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
        vecs[4] = '{din: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
        vecs[5] = '{din: 8'h0D, seq: 8'b1011_0000, par: 1'b1};
        burst_bytes = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0D};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd",   {31'd0, txd},   32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ovf",   {31'd0, ovf},   32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single-byte frames, cycle-exact
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Producer burst: one byte every other cycle, frames back to back
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wr = 1'b1; din = burst_bytes[i];
                    @(negedge clk);
                    wr = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [7:0] bb;
                    recv_frame((k == 0) ? 10 : 0, bb);
                    chk($sformatf("burst_byte%0d", k), {24'd0, bb}, {24'd0, burst_bytes[k]});
                end
            end
        join
        chk("burst_busy_end",  {31'd0, busy},  32'd0);
        chk("burst_empty_end", {31'd0, empty}, 32'd1);
        chk("burst_ovf",       {31'd0, ovf},   32'd0);

        // Overflow: 20 back-to-back writes into a 16-deep FIFO
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    wr = 1'b1; din = 8'(i);
                    @(negedge clk);
                    if (i == 16) begin
                        chk("ovf_full_at_16", {31'd0, full}, 32'd1);
                        chk("ovf_clear_at_16", {31'd0, ovf}, 32'd0);
                    end
                    if (i == 17) chk("ovf_set_at_17", {31'd0, ovf}, 32'd1);
                end
                wr = 1'b0;
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    logic [7:0] ob;
                    recv_frame((k == 0) ? 10 : 0, ob);
                    chk($sformatf("ovf_rx_byte%0d", k), {24'd0, ob}, k);
                end
            end
        join
        chk("ovf_busy_end",  {31'd0, busy},  32'd0);
        chk("ovf_empty_end", {31'd0, empty}, 32'd1);
        chk("ovf_sticky",    {31'd0, ovf},   32'd1);
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("ovf_no_extra_frame", {31'd0, idle_ok}, 32'd1);
        chk("ovf_still_sticky",   {31'd0, ovf},     32'd1);

        // Asynchronous reset during DATA bit 3 of 0x41 (bit 3 = 0)
        wr = 1'b1; din = 8'h41;
        @(negedge clk); wr = 1'b0;
        repeat (CPB * 4 + 2) @(negedge clk);
        chk("mid_txd_before", {31'd0, txd},  32'd0);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_txd",   {31'd0, txd},   32'd1);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_ovf",   {31'd0, ovf},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("mid_idle_after_release", {31'd0, idle_ok}, 32'd1);

        // Write attempted at full on the STOP->START pop edge
        for (int i = 0; i < 17; i++) begin
            wr = 1'b1; din = 8'h50 + 8'(i);
            @(negedge clk);
            if (i == 0) c1 = cyc;
        end
        wr = 1'b0;
        chk("pw_full_filled", {31'd0, full}, 32'd1);
        chk("pw_ovf_clear",   {31'd0, ovf},  32'd0);
        while (cyc < c1 + 10 * CPB) @(negedge clk);
        chk("pw_full_pre", {31'd0, full}, 32'd1);
        chk("pw_stop_bit", {31'd0, txd},  32'd1);
        wr = 1'b1; din = 8'hEE;
        @(negedge clk);
        wr = 1'b0;
        chk("pw_ovf_set",     {31'd0, ovf},  32'd1);
        chk("pw_full_after",  {31'd0, full}, 32'd0);
        chk("pw_next_start",  {31'd0, txd},  32'd0);
        chk("pw_busy",        {31'd0, busy}, 32'd1);
        wr = 1'b1; din = 8'hEF;
        @(negedge clk);
        wr = 1'b0;
        chk("pw_refill_full", {31'd0, full}, 32'd1);
        chk("pw_ovf_sticky",  {31'd0, ovf},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
